score_video_decoder: RTL
========================

SCORE_VIDEO_DECODER -- requirements
Module: score_video_decoder

Interface
REQ-001 The block SHALL have parameter X_P1T, default 9'd128, giving the h-start of the player-1 tens digit cell.
REQ-002 The block SHALL have parameter X_P1O, default 9'd160, giving the h-start of the player-1 ones digit cell.
REQ-003 The block SHALL have parameter X_P2T, default 9'd320, giving the h-start of the player-2 tens digit cell.
REQ-004 The block SHALL have parameter X_P2O, default 9'd352, giving the h-start of the player-2 ones digit cell.
REQ-005 The block SHALL have parameter Y_TOP, default 8'd32, giving the v-start of all digit cells; each cell is 16 wide by 32 high.
REQ-006 The block SHALL have parameter FRAME_LINE, default 8'd248, giving the vcnt line that ends capture.
REQ-007 Port clk_sys SHALL be an input of width 1 carrying the system clock.
REQ-008 Port reset SHALL be an input of width 1; reset is synchronous and active-high on clk_sys.
REQ-009 Port ce SHALL be an input of width 1, the pixel clock enable; all sampling is qualified by ce.
REQ-010 Port hcnt SHALL be an input of width 9, the horizontal pixel counter (h256..h1).
REQ-011 Port vcnt SHALL be an input of width 8, the vertical line counter (v128..v1).
REQ-012 Port score SHALL be an input of width 1, the score video pixel (1 = lit).
REQ-013 Port p1_score SHALL be an output of width 8, BCD {tens,ones} for player 1.
REQ-014 Port p2_score SHALL be an output of width 8, BCD {tens,ones} for player 2.
REQ-015 Port valid SHALL be an output of width 1, high once any frame has been committed.
REQ-016 Port upd SHALL be an output of width 1, a one-clk_sys pulse on each committed change.

Function
REQ-017 Per cell origin (X,Y), segment sample points SHALL be: a(X+8,Y+2) b(X+14,Y+8) c(X+14,Y+24) d(X+8,Y+30) e(X+2,Y+24) f(X+2,Y+8) g(X+8,Y+16).
REQ-018 On ce with {hcnt,vcnt} equal to a sample point, score SHALL be latched into the matching bit of a 28-bit shadow register (4 digits x 7 segments).
REQ-019 The FSM SHALL have states IDLE, CAPTURE, DECODE and COMMIT; it leaves IDLE on the first ce and enters CAPTURE.
REQ-020 In CAPTURE, on ce with vcnt==FRAME_LINE and hcnt==0, the shadow SHALL be copied to a snapshot, the shadow SHALL be cleared, and the FSM SHALL enter DECODE.
REQ-021 DECODE SHALL decode one digit per clk_sys (P1T, P1O, P2T, P2O), taking 4 clocks, then enter COMMIT.
REQ-022 Decode SHALL use the standard 7-segment patterns for 0-9 (1 = b,c only; 7 = a,b,c); all segments off SHALL decode to 4'hF (blank); any other pattern SHALL decode to 4'hE (invalid).
REQ-023 The COMMIT stage SHALL last 1 clock, then return to CAPTURE; total latency from the frame-end ce to output update SHALL be 5 clk_sys.
REQ-024 At COMMIT, a blank tens digit SHALL be reported as 0; a frame containing any 4'hE digit, or a blank ones digit, SHALL be discarded (no output change, no upd).
REQ-025 At COMMIT of an accepted frame, p1_score and p2_score SHALL be updated, valid SHALL be set, and upd SHALL pulse only if either value differs from the previous outputs.
REQ-026 Sampling SHALL continue into the cleared shadow during DECODE and COMMIT; a frame-end event outside CAPTURE SHALL be ignored.

Reset
REQ-027 Reset SHALL force the FSM to IDLE, the shadow and snapshot to 0, p1_score and p2_score to 8'h00, and valid and upd to 0.
REQ-028 Reset asserted during DECODE or COMMIT SHALL abort the decode without any output update.

Configuration
REQ-029 With SCORE_DECODE_DEBOUNCE_EN defined, an accepted frame SHALL commit only if its decoded digits equal those of the immediately preceding accepted frame (a two-frame agreement); otherwise it SHALL be stored as the new candidate and not committed.
REQ-030 Without SCORE_DECODE_DEBOUNCE_EN, every accepted frame SHALL commit.

Verification
REQ-031 Reset, then drive one frame rendering P1 "3" (tens blank) and P2 "12" -> 5 clocks after frame end, p1_score=8'h03, p2_score=8'h12, valid=1, and upd pulses once (or on the second identical frame with debounce).
REQ-032 Repeat the identical frame -> outputs are unchanged and upd stays 0.
REQ-033 Drive a frame with P2 ones showing the segment pattern a+g only -> the frame is discarded and outputs hold their previous values.
REQ-034 With debounce enabled, alternate frames "05" and "06" for P1 -> no commit occurs; then two consecutive "06" frames -> p1_score=8'h06 with one upd pulse.
REQ-035 Assert reset on the 2nd clock of DECODE -> all outputs are 0 and no upd occurs; the next full frame then decodes normally.
REQ-036 Hold ce=0 across the frame-end position -> no capture and no decode occur.

Source files
------------

// File: rtl/score_video_decoder.sv
`default_nettype none
// ============================================================================
// Module   : score_video_decoder
// Purpose  : Recovers two 2-digit BCD scores from a 7-segment score video
//            stream. Each segment is sampled at a fixed screen position.
//            Digits are decoded once per frame. A frame is committed only if
//            it decodes cleanly.
// Options  : SCORE_DECODE_DEBOUNCE_EN - when defined, a frame commits only
//            if it agrees with the previously accepted frame.
// Revision : 1.0 - initial release
// ============================================================================
module score_video_decoder #(
    parameter logic [8:0] X_P1T      = 9'd128,
    parameter logic [8:0] X_P1O      = 9'd160,
    parameter logic [8:0] X_P2T      = 9'd320,
    parameter logic [8:0] X_P2O      = 9'd352,
    parameter logic [7:0] Y_TOP      = 8'd32,
    parameter logic [7:0] FRAME_LINE = 8'd248
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce,
    input  logic [8:0] hcnt,
    input  logic [7:0] vcnt,
    input  logic       score,
    output logic [7:0] p1_score,
    output logic [7:0] p2_score,
    output logic       valid,
    output logic       upd
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_DECODE  = 2'd2;
    localparam logic [1:0] S_COMMIT  = 2'd3;

    // Horizontal origin of digit cell d (0=P1 tens, 1=P1 ones, 2=P2 tens, 3=P2 ones)
    function automatic logic [8:0] cell_x(input int d);
        case (d)
            0:       return X_P1T;
            1:       return X_P1O;
            2:       return X_P2T;
            default: return X_P2O;
        endcase
    endfunction

    // Sample offsets inside a 16x32 cell, segment order a,b,c,d,e,f,g
    function automatic logic [8:0] seg_dx(input int s);
        case (s)
            0:       return 9'd8;
            1:       return 9'd14;
            2:       return 9'd14;
            3:       return 9'd8;
            4:       return 9'd2;
            5:       return 9'd2;
            default: return 9'd8;
        endcase
    endfunction

    function automatic logic [7:0] seg_dy(input int s);
        case (s)
            0:       return 8'd2;
            1:       return 8'd8;
            2:       return 8'd24;
            3:       return 8'd30;
            4:       return 8'd24;
            5:       return 8'd8;
            default: return 8'd16;
        endcase
    endfunction

    // Segment pattern {g,f,e,d,c,b,a} to digit; blank -> F, anything odd -> E
    function automatic logic [3:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   return 4'h0;
            7'h06:   return 4'h1;
            7'h5B:   return 4'h2;
            7'h4F:   return 4'h3;
            7'h66:   return 4'h4;
            7'h6D:   return 4'h5;
            7'h7D:   return 4'h6;
            7'h07:   return 4'h7;
            7'h7F:   return 4'h8;
            7'h6F:   return 4'h9;
            7'h00:   return 4'hF;
            default: return 4'hE;
        endcase
    endfunction

    logic [1:0]  r_state;
    logic [1:0]  r_dec_idx;
    logic [27:0] r_shadow;
    logic [27:0] r_snap;
    logic [3:0]  r_dig [4];
    logic [7:0]  r_p1_score;
    logic [7:0]  r_p2_score;
    logic        r_valid;
    logic        r_upd;

    logic [27:0] w_hit;
    logic        w_frame_end;
    logic [6:0]  w_dec_seg;
    logic [3:0]  w_p1t;
    logic [3:0]  w_p2t;
    logic [7:0]  w_new_p1;
    logic [7:0]  w_new_p2;
    logic        w_reject;
    logic        w_commit_ok;

    // One comparator per segment sample point; bit index = digit*7 + segment
    generate
        for (genvar d = 0; d < 4; d++) begin : g_digit
            for (genvar s = 0; s < 7; s++) begin : g_seg
                localparam logic [8:0] C_PX = cell_x(d) + seg_dx(s);
                localparam logic [7:0] C_PY = Y_TOP + seg_dy(s);
                assign w_hit[d*7+s] = (hcnt == C_PX) && (vcnt == C_PY);
            end
        end
    endgenerate

    assign w_frame_end = ce && (hcnt == 9'd0) && (vcnt == FRAME_LINE);

    // Latch lit/unlit at each sample point; snapshot and clear at frame end
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_shadow <= '0;
            r_snap   <= '0;
        end else if ((r_state == S_CAPTURE) && w_frame_end) begin
            r_snap   <= r_shadow;
            r_shadow <= '0;
        end else if (ce) begin
            r_shadow <= (r_shadow & ~w_hit) | ({28{score}} & w_hit);
        end
    end

    // Select the segment group of the digit currently being decoded
    always_comb begin
        w_dec_seg = r_snap[6:0];
        case (r_dec_idx)
            2'd1:    w_dec_seg = r_snap[13:7];
            2'd2:    w_dec_seg = r_snap[20:14];
            2'd3:    w_dec_seg = r_snap[27:21];
            default: w_dec_seg = r_snap[6:0];
        endcase
    end

    // Blank tens read as zero; bad segments or a blank ones digit spoil the frame
    always_comb begin
        w_p1t    = (r_dig[0] == 4'hF) ? 4'h0 : r_dig[0];
        w_p2t    = (r_dig[2] == 4'hF) ? 4'h0 : r_dig[2];
        w_new_p1 = {w_p1t, r_dig[1]};
        w_new_p2 = {w_p2t, r_dig[3]};
        w_reject = (r_dig[0] == 4'hE) || (r_dig[1] == 4'hE) ||
                   (r_dig[2] == 4'hE) || (r_dig[3] == 4'hE) ||
                   (r_dig[1] == 4'hF) || (r_dig[3] == 4'hF);
    end

`ifdef SCORE_DECODE_DEBOUNCE_EN
    logic [15:0] r_cand;
    logic        r_cand_ok;

    // Remember the last accepted frame so the next one can confirm it
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cand    <= '0;
            r_cand_ok <= 1'b0;
        end else if ((r_state == S_COMMIT) && !w_reject) begin
            r_cand    <= {w_new_p1, w_new_p2};
            r_cand_ok <= 1'b1;
        end
    end

    assign w_commit_ok = !w_reject && r_cand_ok && (r_cand == {w_new_p1, w_new_p2});
`else
    assign w_commit_ok = !w_reject;
`endif

    // Frame FSM: capture, decode one digit per clock, then commit
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_dec_idx  <= 2'd0;
            r_p1_score <= 8'h00;
            r_p2_score <= 8'h00;
            r_valid    <= 1'b0;
            r_upd      <= 1'b0;
            for (int i = 0; i < 4; i++) r_dig[i] <= 4'h0;
        end else begin
            r_upd <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ce) r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (w_frame_end) begin
                        r_state   <= S_DECODE;
                        r_dec_idx <= 2'd0;
                    end
                end
                S_DECODE: begin
                    r_dig[r_dec_idx] <= seg_decode(w_dec_seg);
                    r_dec_idx        <= r_dec_idx + 2'd1;
                    if (r_dec_idx == 2'd3) r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    r_state <= S_CAPTURE;
                    if (w_commit_ok) begin
                        r_p1_score <= w_new_p1;
                        r_p2_score <= w_new_p2;
                        r_valid    <= 1'b1;
                        r_upd      <= ({w_new_p1, w_new_p2} != {r_p1_score, r_p2_score});
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign p1_score = r_p1_score;
    assign p2_score = r_p2_score;
    assign valid    = r_valid;
    assign upd      = r_upd;

endmodule
`default_nettype wire
